mvm_seq_ctrl: RTL and testbench
===============================

// Module: mvm_seq_ctrl
// PURPOSE
//  Sequencer for the 8x8 matrix-vector multiply datapath (mat_vec_mult_t): A-row FIFOs, B FIFO, MAC array.
//  Accepts one job as a valid/ready word stream and steers each word into the correct FIFO (a_wren/b_wren).
//  Issues skewed FIFO reads for the compute phase, waits out the MAC pipeline, then pulses done.
//  Sits between the host-side stream source and the datapath; owns the datapath Clr.
// PARAMETERS
//  DATA_WIDTH  8  width of stream word and FIFO entries
//  DIM         8  matrix rows = columns = vector length = FIFO depth
//  MAC_LAT     2  cycles from last read to final accumulator update (DRAIN length, >=1)
// PORTS
//  clk        in   1              clock; all state updates on posedge
//  rst        in   1              asynchronous reset, active-high
//  start      in   1              begin a job; sampled only in IDLE
//  in_valid   in   1              stream word valid
//  in_ready   out  1              stream word accepted when in_valid&in_ready at posedge
//  in_data    in   DATA_WIDTH     stream word
//  a_wren     out  DIM            one-hot write enable to A-row FIFO r
//  a_fifo_in  out  DATA_WIDTH     write data to A FIFOs (= in_data)
//  b_wren     out  1              write enable to B FIFO
//  b_fifo_in  out  DATA_WIDTH     write data to B FIFO (= in_data)
//  a_rden     out  DIM            per-row A FIFO read enable
//  b_rden     out  1              B FIFO read enable
//  clr        out  1              synchronous clear to datapath accumulators/FIFOs
//  busy       out  1              high in every state except IDLE
//  done       out  1              one-cycle pulse at job completion
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0; every output 0 (in_ready=0, done=0, clr=0).
//  FSM: IDLE -> CLR -> LOAD -> COMPUTE -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 -> CLR next edge. start ignored in all other states (no queueing).
//  CLR: exactly 1 cycle, clr=1; -> LOAD.
//  LOAD: in_ready=1. Stream order: for r=0..DIM-1: DIM words for A row r, then 1 word B[r].
//   Counters row (0..DIM-1), col (0..DIM, col==DIM = B slot).
//   a_wren = (in_valid && col<DIM) ? 1<<row : 0; b_wren = in_valid && col==DIM. Combinational.
//   in_valid=0 stalls: no wren, counters hold, no timeout.
//   After DIM*(DIM+1) accepted words -> COMPUTE on the edge accepting the last word.
//  COMPUTE: cycle counter k=0..2*DIM-2 (2*DIM-1 cycles); in_ready=0.
//   b_rden=1 for k in [0,DIM-1]; a_rden[r]=1 for k in [r,r+DIM-1] (row r skewed by r).
//   Each FIFO read exactly DIM times; -> DRAIN after k=2*DIM-2.
//  DRAIN: MAC_LAT cycles, no enables; -> DONE.
//  DONE: done=1 one cycle, busy=1; -> IDLE. start in DONE ignored.
//  All rden/wren/clr/done mutually consistent: no wren outside LOAD, no rden outside COMPUTE.
//  Async rst mid-job: immediate return to IDLE, outputs 0; partial FIFO contents are not cleared
//   until next job's CLR cycle.
//  Counters sized $clog2(2*DIM) bits; no wrap possible within a job.
//  Timing (MAC_LAT=2, continuous in_valid): start sampled at edge E0; clr high E0..E1;
//   words accepted E2..E73; done high E90..E91.
// CONFIGURATION
//  MVM_SEQ_CTRL_PERF_EN defined: adds outputs job_cycles[31:0] and stall_cycles[31:0].
//   job_cycles = cycles from CLR entry to DONE of last job; stall_cycles = LOAD cycles with in_valid=0.
//   Both reset to 0, update once in DONE, hold otherwise.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs 0 immediately, state IDLE, in_ready=0.
//  2 Job: A rows all [0..7], B=[1..8], in_valid continuous -> done at E90, every out[i]=168.
//  3 Stalls: same job, in_valid low every 3rd cycle -> same results; done delayed by stall count;
//   PERF_EN: stall_cycles equals bench-counted low cycles.
//  4 Skew check: during COMPUTE a_rden[r] high exactly cycles r..r+7, b_rden cycles 0..7; 8 reads each.
//  5 start pulsed during LOAD and DONE -> ignored; only one done pulse; busy stays 1 until IDLE.
//  6 rst asserted after 30 accepted words, then new job A=I (identity), B=[1..8] -> out[i]=i+1.

Source files
------------

// File: rtl/mvm_seq_ctrl.sv
// rtl/mvm_seq_ctrl.sv - job sequencer for the 8x8 matrix-vector multiply datapath (FIFO steering, skewed reads, drain).
// Optional build macro MVM_SEQ_CTRL_PERF_EN adds job_cycles/stall_cycles performance outputs.
module mvm_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = 8,
    parameter int MAC_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DIM-1:0]        a_wren,
    output logic [DATA_WIDTH-1:0] a_fifo_in,
    output logic                  b_wren,
    output logic [DATA_WIDTH-1:0] b_fifo_in,
    output logic [DIM-1:0]        a_rden,
    output logic                  b_rden,
    output logic                  clr,
    output logic                  busy,
    output logic                  done
`ifdef MVM_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]           job_cycles,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int CW = $clog2(2 * DIM);
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [CW-1:0] COL_B      = CW'(DIM);
    localparam logic [CW-1:0] ROW_LAST   = CW'(DIM - 1);
    localparam logic [CW-1:0] K_LAST     = CW'(2 * DIM - 2);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  row;
    logic [CW-1:0]  col;
    logic [CW-1:0]  k;
    logic [DW-1:0]  drain_cnt;
    logic           accept;
    logic           load_last;

    assign a_fifo_in = in_data;
    assign b_fifo_in = in_data;

    assign accept    = (state == S_LOAD) && in_valid;
    assign load_last = accept && (col == COL_B) && (row == ROW_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // col counts A words of the current row; col == DIM is the B slot that closes the row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row       <= '0;
            col       <= '0;
            k         <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_CLR: begin
                    row       <= '0;
                    col       <= '0;
                    k         <= '0;
                    drain_cnt <= '0;
                end
                S_LOAD: begin
                    if (accept) begin
                        if (col == COL_B) begin
                            col <= '0;
                            if (row != ROW_LAST) begin
                                row <= row + CW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (k != K_LAST) begin
                        k <= k + CW'(1);
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        clr      = 1'b0;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        a_wren   = '0;
        b_wren   = 1'b0;
        a_rden   = '0;
        b_rden   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_CLR;
                end
            end
            S_CLR: begin
                clr      = 1'b1;
                state_nx = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (col == COL_B) begin
                        b_wren = 1'b1;
                    end else begin
                        a_wren = {{(DIM-1){1'b0}}, 1'b1} << row;
                    end
                end
                if (load_last) begin
                    state_nx = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                // row r lags row 0 by r cycles so each B element meets every A row in the systolic chain
                b_rden = (k < COL_B);
                for (int r = 0; r < DIM; r++) begin
                    a_rden[r] = (int'(k) >= r) && (int'(k) <= r + DIM - 1);
                end
                if (k == K_LAST) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

`ifdef MVM_SEQ_CTRL_PERF_EN
    logic [31:0] job_cnt;
    logic [31:0] stall_cnt;

    // job_cnt spans CLR through DRAIN, so at DONE it holds the CLR-entry-to-DONE distance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_cnt      <= '0;
            stall_cnt    <= '0;
            job_cycles   <= '0;
            stall_cycles <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    job_cnt   <= '0;
                    stall_cnt <= '0;
                end
                S_DONE: begin
                    job_cycles   <= job_cnt;
                    stall_cycles <= stall_cnt;
                end
                default: begin
                    job_cnt <= job_cnt + 32'd1;
                    if ((state == S_LOAD) && !in_valid) begin
                        stall_cnt <= stall_cnt + 32'd1;
                    end
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// tb/tb_mvm_seq_ctrl.sv - self-checking bench for mvm_seq_ctrl with a queue-based FIFO/MAC reference model.
module tb_mvm_seq_ctrl;

    localparam int N  = 8;
    localparam int ML = 2;
    localparam int WORDS = N * (N + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic [N-1:0] a_wren;
    logic [7:0] a_fifo_in;
    logic       b_wren;
    logic [7:0] b_fifo_in;
    logic [N-1:0] a_rden;
    logic       b_rden;
    logic       clr;
    logic       busy;
    logic       done;
`ifdef MVM_SEQ_CTRL_PERF_EN
    logic [31:0] job_cycles;
    logic [31:0] stall_cycles;
`endif

    mvm_seq_ctrl #(.DATA_WIDTH(8), .DIM(N), .MAC_LAT(ML)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .a_wren    (a_wren),
        .a_fifo_in (a_fifo_in),
        .b_wren    (b_wren),
        .b_fifo_in (b_fifo_in),
        .a_rden    (a_rden),
        .b_rden    (b_rden),
        .clr       (clr),
        .busy      (busy),
        .done      (done)
`ifdef MVM_SEQ_CTRL_PERF_EN
        ,
        .job_cycles   (job_cycles),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int mat_a [N][N];
    int vec_b [N];

    int aq [N][$];
    int bq [$];
    int aread [N][$];
    int bread [$];

    int cyc = 0;
    int clr_cyc, last_acc_cyc, done_cyc;
    int done_cnt, clr_cnt, skew_err, proto_err, busy_err, acc_words;
    bit in_job = 1'b0;

    function automatic logic [7:0] word_at(input int idx);
        int r;
        int c;
        r = idx / (N + 1);
        c = idx % (N + 1);
        if (c < N) return 8'(mat_a[r][c]);
        return 8'(vec_b[r]);
    endfunction

    // datapath model: FIFOs as queues, cleared by clr, written by wren and popped by rden
    initial begin
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (rst) begin
                in_job = 1'b0;
            end else begin
                if (clr) begin
                    for (int r = 0; r < N; r++) aq[r].delete();
                    bq.delete();
                    clr_cnt++;
                    clr_cyc = cyc;
                    in_job  = 1'b1;
                    if (a_wren != 0 || b_wren || a_rden != 0 || b_rden || done) proto_err++;
                end
                if ((a_wren != 0 || b_wren) && !(in_ready && in_valid)) proto_err++;
                if ((a_rden != 0 || b_rden) && in_ready) proto_err++;
                if (a_fifo_in != in_data || b_fifo_in != in_data) proto_err++;
                if (in_valid && in_ready) begin
                    int r;
                    int c;
                    logic [N-1:0] exp_a;
                    r = acc_words / (N + 1);
                    c = acc_words % (N + 1);
                    exp_a = (c < N) ? (N'(1) << r) : '0;
                    if (a_wren != exp_a || b_wren != (c == N)) proto_err++;
                    acc_words++;
                    last_acc_cyc = cyc;
                end
                for (int r = 0; r < N; r++) if (a_wren[r]) aq[r].push_back(int'(a_fifo_in));
                if (b_wren) bq.push_back(int'(b_fifo_in));
                if (b_rden) begin
                    if (bq.size() == 0) proto_err++;
                    else begin
                        if (cyc != last_acc_cyc + 1 + bread.size()) skew_err++;
                        bread.push_back(bq.pop_front());
                    end
                end
                for (int r = 0; r < N; r++) begin
                    if (a_rden[r]) begin
                        if (aq[r].size() == 0) proto_err++;
                        else begin
                            if (cyc != last_acc_cyc + 1 + r + aread[r].size()) skew_err++;
                            aread[r].push_back(aq[r].pop_front());
                        end
                    end
                end
                if (busy != in_job) busy_err++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    in_job   = 1'b0;
                end
            end
        end
    end

    task automatic start_job();
        @(negedge clk);
        done_cnt = 0; clr_cnt = 0; skew_err = 0; proto_err = 0; busy_err = 0; acc_words = 0;
        for (int r = 0; r < N; r++) aread[r].delete();
        bread.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int mode, input bit poke, input int max_words, output int stalls);
        int cnt;
        int c;
        int guard;
        cnt = 0; c = 0; guard = 0; stalls = 0;
        while (!in_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        while (cnt < max_words) begin
            bit v;
            v = 1'b1;
            if (mode == 1 && (c % 3) == 2) v = 1'b0;
            if (mode == 2 && $urandom_range(0, 3) == 0) v = 1'b0;
            c++;
            if (!in_ready) begin
                check("ready_lost", 0, 1);
                break;
            end
            in_valid = v;
            in_data  = word_at(cnt);
            start    = poke && cnt == 20 && v;
            if (v) cnt++;
            else stalls++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'd0;
        start    = 1'b0;
    endtask

    task automatic finish_job(input int stalls, input bit poke);
        int g;
        int busy_seen;
        longint got;
        longint exp;
        g = 0;
        while (!done && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!done) begin
            check("done_timeout", 0, 1);
            return;
        end
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_seen = 0;
        repeat (5) begin
            if (busy) busy_seen++;
            @(negedge clk);
        end
        check("done_pulses", done_cnt, 1);
        check("clr_pulses", clr_cnt, 1);
        check("idle_after_done", busy_seen, 0);
        check("latency", done_cyc - clr_cyc, 1 + WORDS + stalls + (2 * N - 1) + ML);
        check("words", acc_words, WORDS);
        check("b_reads", bread.size(), N);
        check("skew_errs", skew_err, 0);
        check("proto_errs", proto_err, 0);
        check("busy_errs", busy_err, 0);
        for (int r = 0; r < N; r++) begin
            exp = 0;
            for (int c = 0; c < N; c++) exp += mat_a[r][c] * vec_b[c];
            got = -1;
            if (aread[r].size() == N && bread.size() == N) begin
                got = 0;
                for (int j = 0; j < N; j++) got += aread[r][j] * bread[j];
            end
            check($sformatf("out%0d", r), got, exp);
        end
`ifdef MVM_SEQ_CTRL_PERF_EN
        check("job_cycles", job_cycles, 1 + WORDS + stalls + (2 * N - 1) + ML);
        check("stall_cycles", stall_cycles, stalls);
`endif
    endtask

    task automatic run_job(input int mode, input bit poke);
        int st;
        start_job();
        feed(mode, poke, WORDS, st);
        finish_job(st, poke);
    endtask

    task automatic fill_random();
        for (int r = 0; r < N; r++) begin
            vec_b[r] = int'($urandom_range(0, 255));
            for (int c = 0; c < N; c++) mat_a[r][c] = int'($urandom_range(0, 255));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        #1;
        check("reset_outputs", {in_ready, a_wren, b_wren, a_rden, b_rden, clr, busy, done}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", {in_ready, a_wren, b_wren, a_rden, b_rden, clr, busy, done}, 0);

        for (int r = 0; r < N; r++) begin
            vec_b[r] = r + 1;
            for (int c = 0; c < N; c++) mat_a[r][c] = c;
        end
        run_job(0, 1'b0);
        run_job(1, 1'b0);

        fill_random();
        run_job(2, 1'b1);

        fill_random();
        start_job();
        feed(0, 1'b0, 30, st);
        @(posedge clk);
        #3;
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_outputs", {in_ready, a_wren, b_wren, a_rden, b_rden, clr, busy, done}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < N; r++) begin
            vec_b[r] = r + 1;
            for (int c = 0; c < N; c++) mat_a[r][c] = (r == c) ? 1 : 0;
        end
        run_job(0, 1'b0);

        repeat (2) begin
            fill_random();
            run_job(2, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
